harmony_voice_sched: RTL and testbench
======================================

// Module: harmony_voice_sched
// PURPOSE
// - Time-multiplexes one shared sine ROM (wave_sine style, DEPTH entries, ROM_LAT read latency) among NUM_H harmonic voices.
// - Voice k (k=1..NUM_H) runs at k x fundamental phase step.
// - Once per i_sample_tick: sequences one ROM read per voice, applies the per-voice gain shift, and sums the enabled voices.
// - Emits one mixed sample with a 1-cycle valid strobe; sits between the sample-rate tick generator and the output filter chain.
// PARAMETERS
// - WIDTH   24   ROM sample width (signed two's complement)
// - DEPTH   512  ROM entries; must be a power of 2; AW = $clog2(DEPTH)
// - NUM_H   4    number of harmonic voices, >=1
// - ROM_LAT 1    cycles from o_rom_addr/o_rom_en to valid i_rom_data, >=1
// PORTS
// - i_clk           in   1                          clock
// - i_rst           in   1                          reset, asynchronous active-high
// - i_sample_tick   in   1                          start-of-sample request (1-cycle pulse)
// - i_fund_step     in   AW                         fundamental phase step
// - i_voice_en      in   NUM_H                      bit k-1 enables voice k in the sum
// - i_voice_gain    in   2*NUM_H                    [2k-1:2k-2] = gain code of voice k
// - o_rom_en        out  1                          ROM read strobe
// - o_rom_addr      out  AW                         ROM address
// - i_rom_data      in   WIDTH                      ROM read data
// - o_sample        out  WIDTH+$clog2(NUM_H)+1 (SW)  signed mixed sample
// - o_sample_valid  out  1                          o_sample updated this cycle
// - o_busy          out  1                          frame in progress (state != IDLE)
// - o_overrun       out  1                          1-cycle pulse: tick dropped while busy
// BEHAVIOUR
// - Reset (async, any state): all outputs 0, all voice phases 0, acc 0, state IDLE.
// - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE, tick=1: latch i_fund_step, i_voice_en, i_voice_gain into shadow regs; clear acc; idx=0; go to ISSUE.
//   - Inputs changing mid-frame have no effect on the current frame.
// - ISSUE: NUM_H cycles, one voice per cycle, idx 0..NUM_H-1.
//   - Registered o_rom_en=1, o_rom_addr=phase[idx].
//   - Then phase[idx] += (idx+1)*step_shadow, modulo DEPTH (natural AW-bit wrap).
// - Return path: idx delayed ROM_LAT cycles tags i_rom_data; enabled voices add the shifted term to acc, disabled voices add 0.
//   - Every voice is read regardless of enable, so latency is fixed.
// - Gain (arithmetic right shift, sign-extended to SW): code 0 >>>6, 1 >>>5, 2 >>>4, 3 >>>3.
// - acc is SW bits signed; no saturation needed, since sum of NUM_H terms cannot overflow SW.
// - DRAIN: held until the last tagged return has been accumulated.
// - DONE: o_sample<=acc, o_sample_valid=1 for exactly one cycle; o_sample holds until the next DONE.
// - Latency: tick sampled at edge T -> ROM reads in cycles T+1..T+NUM_H.
//   - o_sample_valid is high in cycle T+NUM_H+ROM_LAT+1 (defaults: 6 cycles).
// - o_rom_en=0 outside ISSUE; o_rom_addr holds its last value.
// - Tick in ISSUE/DRAIN: ignored, o_overrun pulses next cycle, phases unaffected.
// - Tick in DONE: accepted as in IDLE, goes straight to ISSUE; no overrun.
// - First frame after reset reads address 0 for every voice.
// TESTING (defaults; ROM model returns data = addr<<8 after ROM_LAT unless noted)
// - Reset: hold i_rst 3 cycles -> every output 0, state IDLE, o_busy=0.
// - step=8, en=4'b0001, gain v1=3; tick 1 -> addrs 0,0,0,0, sample=0 valid at T+6.
//   tick 2 -> addrs 8,16,24,32; sample=2048>>>3=256.
// - ROM returns constant 24'hFFFFC0 (-64), en=4'b1111, all gains 0 -> each term -1, o_sample=-4 (SW-bit sign-extended).
// - Wrap: step=200, voice 4 -> its addr 0, then 800 mod 512=288, then 1600 mod 512=64 on successive frames.
// - Overrun: second tick 2 cycles after first -> o_overrun 1-cycle pulse, one valid only, phases advanced once.
// - Reset asserted in ISSUE cycle 2 -> no o_sample_valid, phases 0; next tick restarts from addr 0.
// - Change i_fund_step/i_voice_gain during ISSUE -> current sample uses latched values; next frame uses new values.

Source files
------------

// File: rtl/harmony_voice_sched.sv
// harmony_voice_sched
// Shares one sine ROM among NUM_H harmonic voices. Each i_sample_tick starts
// a frame: one ROM read per voice (voice k steps at k x the fundamental), each
// return is gain-shifted and summed over the enabled voices, and the mixed
// sample is emitted with a one-cycle valid strobe.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_sample_tick      start-of-sample request pulse
//   i_fund_step        fundamental phase step (AW bits)
//   i_voice_en         bit k-1 enables voice k in the sum
//   i_voice_gain       [2k-1:2k-2] = gain code of voice k (shift 6 - code)
//   o_rom_en           ROM read strobe
//   o_rom_addr         ROM address
//   i_rom_data         ROM read data, ROM_LAT cycles after o_rom_en
//   o_sample           signed mixed sample (SW bits)
//   o_sample_valid     o_sample updated this cycle
//   o_busy             frame in progress
//   o_overrun          one-cycle pulse when a tick was dropped while busy
module harmony_voice_sched #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned NUM_H   = 4,
    parameter int unsigned ROM_LAT = 1,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned SW     = WIDTH + $clog2(NUM_H) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sample_tick,
    input  logic [AW-1:0]         i_fund_step,
    input  logic [NUM_H-1:0]      i_voice_en,
    input  logic [2*NUM_H-1:0]    i_voice_gain,
    output logic                  o_rom_en,
    output logic [AW-1:0]         o_rom_addr,
    input  logic [WIDTH-1:0]      i_rom_data,
    output logic [SW-1:0]         o_sample,
    output logic                  o_sample_valid,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam int unsigned IW = (NUM_H > 1) ? $clog2(NUM_H) : 1;
    localparam int unsigned MW = AW + IW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [AW-1:0]             r_phase [NUM_H];
    logic [AW-1:0]             r_step;
    logic [NUM_H-1:0]          r_en;
    logic [2*NUM_H-1:0]        r_gain;
    logic [IW-1:0]             r_idx;

    logic [ROM_LAT:0]          r_tag_v;
    logic [IW-1:0]             r_tag_idx [ROM_LAT+1];

    logic signed [SW-1:0]      r_acc;

    logic                      r_rom_en;
    logic [AW-1:0]             r_rom_addr;
    logic [SW-1:0]             r_sample;
    logic                      r_sample_valid;
    logic                      r_busy;
    logic                      r_overrun;

    logic                      w_accept;
    logic                      w_ret_v;
    logic [IW-1:0]             w_ret_idx;
    logic                      w_last_ret;
    logic                      w_ret_en;
    logic [1:0]                w_ret_gain;
    logic [AW-1:0]             w_phase_inc;
    logic signed [SW-1:0]      w_data_ext;
    logic signed [SW-1:0]      w_term;
    logic signed [SW-1:0]      w_term_g;
    logic signed [SW-1:0]      w_acc_nxt;

    logic                      w_rom_en_d;
    logic [AW-1:0]             w_rom_addr_d;
    logic [SW-1:0]             w_sample_d;
    logic                      w_sample_valid_d;
    logic                      w_busy_d;
    logic                      w_overrun_d;

    // A tick starts a frame from IDLE or DONE; elsewhere it is an overrun.
    assign w_accept   = i_sample_tick && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Return tag: voice index delayed by the ROM latency.
    assign w_ret_v    = r_tag_v[ROM_LAT];
    assign w_ret_idx  = r_tag_idx[ROM_LAT];
    assign w_last_ret = w_ret_v && (w_ret_idx == IW'(NUM_H - 1));

    // Phase increment for the voice being issued: (idx+1) * step, wrapped to AW bits.
    assign w_phase_inc = AW'(MW'(r_step) * (MW'(r_idx) + MW'(1)));

    // Enable and gain of the voice whose data is returning.
    always_comb begin
        w_ret_en   = 1'b0;
        w_ret_gain = 2'd0;
        for (int k = 0; k < NUM_H; k++) begin
            if (w_ret_idx == IW'(k)) begin
                w_ret_en   = r_en[k];
                w_ret_gain = r_gain[2*k +: 2];
            end
        end
    end

    // Gain: arithmetic right shift by (6 - code) after sign extension to SW.
    always_comb begin
        w_data_ext = SW'($signed(i_rom_data));
        w_term     = '0;
        case (w_ret_gain)
            2'd0:    w_term = w_data_ext >>> 6;
            2'd1:    w_term = w_data_ext >>> 5;
            2'd2:    w_term = w_data_ext >>> 4;
            default: w_term = w_data_ext >>> 3;
        endcase
        w_term_g  = (w_ret_v && w_ret_en) ? w_term : '0;
        w_acc_nxt = r_acc + w_term_g;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_sample_tick) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_idx == IW'(NUM_H - 1)) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_ret) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = i_sample_tick ? S_ISSUE : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        w_rom_en_d       = 1'b0;
        w_rom_addr_d     = r_rom_addr;
        w_sample_valid_d = 1'b0;
        w_sample_d       = r_sample;
        w_busy_d         = (w_next_state != S_IDLE);
        w_overrun_d      = 1'b0;
        case (r_state)
            S_ISSUE: begin
                w_rom_en_d   = 1'b1;
                w_rom_addr_d = r_phase[r_idx];
                w_overrun_d  = i_sample_tick;
            end
            S_DRAIN: begin
                w_overrun_d = i_sample_tick;
                // Final return is folded in on the same edge that enters DONE.
                if (w_last_ret) begin
                    w_sample_valid_d = 1'b1;
                    w_sample_d       = w_acc_nxt;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rom_en       <= 1'b0;
            r_rom_addr     <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_rom_en       <= w_rom_en_d;
            r_rom_addr     <= w_rom_addr_d;
            r_sample       <= w_sample_d;
            r_sample_valid <= w_sample_valid_d;
            r_busy         <= w_busy_d;
            r_overrun      <= w_overrun_d;
        end
    end

    // Frame shadow registers and voice index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_step <= '0;
            r_en   <= '0;
            r_gain <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_step <= i_fund_step;
            r_en   <= i_voice_en;
            r_gain <= i_voice_gain;
            r_idx  <= '0;
        end else if (r_state == S_ISSUE) begin
            r_idx  <= r_idx + IW'(1);
        end
    end

    // Voice phase accumulators, advanced once as each voice is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_H; k++) r_phase[k] <= '0;
        end else if (r_state == S_ISSUE) begin
            r_phase[r_idx] <= r_phase[r_idx] + w_phase_inc;
        end
    end

    // Tag pipeline: stage 0 aligns with o_rom_en, stage ROM_LAT with i_rom_data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag_v <= '0;
            for (int s = 0; s <= ROM_LAT; s++) r_tag_idx[s] <= '0;
        end else begin
            r_tag_v[0]   <= (r_state == S_ISSUE);
            r_tag_idx[0] <= r_idx;
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_tag_v[s]   <= r_tag_v[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    // Mix accumulator, cleared at frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (w_ret_v) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_rom_en       = r_rom_en;
    assign o_rom_addr     = r_rom_addr;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = r_busy;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_harmony_voice_sched.sv
// Scoreboard bench for harmony_voice_sched: stimulus pushes expected ROM
// addresses and mixed samples (with their due cycle); a negedge monitor pops
// and compares whenever the DUT strobes o_rom_en or o_sample_valid.
module tb_harmony_voice_sched;

    localparam int unsigned WIDTH   = 24;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned NUM_H   = 4;
    localparam int unsigned ROM_LAT = 1;
    localparam int unsigned AW      = 9;
    localparam int unsigned SW      = 27;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tick;
    logic [AW-1:0]        fund_step;
    logic [NUM_H-1:0]     voice_en;
    logic [2*NUM_H-1:0]   voice_gain;
    logic                 rom_en;
    logic [AW-1:0]        rom_addr;
    logic [WIDTH-1:0]     rom_data;
    logic [SW-1:0]        sample;
    logic                 sample_valid;
    logic                 busy;
    logic                 overrun;

    typedef struct {
        longint smp;
        int     due;
    } exp_t;

    exp_t   exp_q[$];
    int     addr_q[$];
    int     n_pass  = 0;
    int     n_total = 0;
    int     cyc     = 0;
    int     ovr_cnt = 0;
    logic   rom_const = 1'b0;
    exp_t   mon_e;
    int     mon_a;

    always #5 clk = ~clk;

    harmony_voice_sched #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_H(NUM_H), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sample_tick(tick),
        .i_fund_step(fund_step), .i_voice_en(voice_en), .i_voice_gain(voice_gain),
        .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_sample(sample), .o_sample_valid(sample_valid),
        .o_busy(busy), .o_overrun(overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency ROM: addr<<8, or constant -64 when rom_const is set.
    always @(posedge clk) rom_data <= rom_const ? 24'hFFFFC0 : (24'(rom_addr) << 8);

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic flag(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares every ROM read and every sample strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                if (addr_q.size() == 0) flag("unexpected rom read");
                else begin
                    mon_a = addr_q.pop_front();
                    chk("rom_addr", longint'(rom_addr), longint'(mon_a));
                end
            end
            if (sample_valid) begin
                if (exp_q.size() == 0) flag("unexpected sample_valid");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("sample", longint'($signed(sample)), mon_e.smp);
                    chk("valid_cycle", longint'(cyc), longint'(mon_e.due));
                end
            end
            if (overrun) ovr_cnt++;
        end
    end

    // Issue a tick and queue the expected four addresses and mixed sample.
    task automatic do_frame(input logic [AW-1:0] step, input logic [NUM_H-1:0] en,
                            input logic [2*NUM_H-1:0] gain,
                            input int a0, input int a1, input int a2, input int a3,
                            input longint smp);
        exp_t e;
        fund_step  = step;
        voice_en   = en;
        voice_gain = gain;
        tick       = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        addr_q.push_back(a0);
        addr_q.push_back(a1);
        addr_q.push_back(a2);
        addr_q.push_back(a3);
        e.smp = smp;
        e.due = cyc + 6;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || addr_q.size() != 0); i++)
            @(posedge clk);
        if (exp_q.size() != 0 || addr_q.size() != 0) flag("timeout waiting for sample");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        fund_step  = '0;
        voice_en   = '0;
        voice_gain = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset rom_en", longint'(rom_en), 0);
        chk("reset rom_addr", longint'(rom_addr), 0);
        chk("reset sample", longint'(sample), 0);
        chk("reset sample_valid", longint'(sample_valid), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset overrun", longint'(overrun), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle busy", longint'(busy), 0);

        // Voice 1 only, gain code 3, step 8.
        do_frame(9'd8, 4'b0001, 8'h03, 0, 0, 0, 0, 0);
        chk("busy in frame", longint'(busy), 1);
        wait_drain();
        do_frame(9'd8, 4'b0001, 8'h03, 8, 16, 24, 32, 256);
        wait_drain();
        do_frame(9'd8, 4'b0001, 8'h03, 16, 32, 48, 64, 512);
        wait_drain();

        // Constant -64 from ROM: sign extension and per-voice gains.
        rom_const = 1'b1;
        do_frame(9'd8, 4'b1111, 8'h00, 24, 48, 72, 96, -4);
        wait_drain();
        do_frame(9'd8, 4'b1111, 8'h1B, 32, 64, 96, 128, -15);
        wait_drain();
        do_frame(9'd8, 4'b1010, 8'h1B, 40, 80, 120, 160, -5);
        wait_drain();
        rom_const = 1'b0;

        // Phase wrap with step 200, voice 4 at gain code 3.
        do_reset();
        do_frame(9'd200, 4'b1000, 8'hC0, 0, 0, 0, 0, 0);
        wait_drain();
        do_frame(9'd200, 4'b1000, 8'hC0, 200, 400, 88, 288, 9216);
        wait_drain();
        do_frame(9'd200, 4'b1000, 8'hC0, 400, 288, 176, 64, 2048);
        wait_drain();

        // Overrun: second tick two cycles after the first is dropped.
        ovr_cnt = 0;
        do_frame(9'd200, 4'b1000, 8'hC0, 88, 176, 264, 352, 11264);
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        wait_drain();
        chk("overrun pulse cycles", longint'(ovr_cnt), 1);
        do_frame(9'd200, 4'b1000, 8'hC0, 288, 64, 352, 128, 4096);
        wait_drain();

        // Reset during ISSUE: no sample, phases restart at 0.
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid-frame reset busy", longint'(busy), 0);
        chk("mid-frame reset rom_en", longint'(rom_en), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        do_frame(9'd200, 4'b1000, 8'hC0, 0, 0, 0, 0, 0);
        wait_drain();
        do_frame(9'd200, 4'b1000, 8'hC0, 200, 400, 88, 288, 9216);
        wait_drain();

        // Inputs changed mid-frame only take effect on the next frame.
        do_frame(9'd200, 4'b1000, 8'hC0, 400, 288, 176, 64, 2048);
        fund_step  = 9'd8;
        voice_gain = 8'h00;
        wait_drain();
        do_frame(9'd8, 4'b1000, 8'h00, 88, 176, 264, 352, 1408);
        wait_drain();

        // Tick during DONE starts the next frame with no overrun.
        ovr_cnt = 0;
        do_frame(9'd8, 4'b1000, 8'h00, 96, 192, 288, 384, 1536);
        repeat (6) @(posedge clk);
        #1;
        chk("in DONE sample_valid", longint'(sample_valid), 1);
        do_frame(9'd8, 4'b1000, 8'h00, 104, 208, 312, 416, 1664);
        wait_drain();
        chk("no overrun on DONE tick", longint'(ovr_cnt), 0);

        repeat (8) @(posedge clk);
        #1;
        chk("leftover samples", longint'(exp_q.size()), 0);
        chk("leftover addresses", longint'(addr_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
